// File: rtl/metronome_beat_sequencer_if.sv
// metronome_beat_sequencer_if: control inputs and beat/tempo outputs of the metronome sequencer
interface metronome_beat_sequencer_if;
  logic       run;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic       beat_tick;
  logic [3:0] beat_num;
  logic       accent;
  logic       beep_en;
  logic [7:0] bpm;
  modport master (output run, btn_up_n, btn_dn_n, input beat_tick, beat_num, accent, beep_en, bpm);
  modport slave (input run, btn_up_n, btn_dn_n, output beat_tick, beat_num, accent, beep_en, bpm);
endinterface

// File: rtl/metronome_beat_sequencer.sv
// metronome_beat_sequencer: debounced tempo buttons, drift-free phase accumulator and beat/accent/beep outputs
module metronome_beat_sequencer #(
  parameter int CLK_HZ          = 27000000,
  parameter int BPM_MIN         = 40,
  parameter int BPM_MAX         = 240,
  parameter int BPM_RESET       = 60,
  parameter int BPM_STEP        = 4,
  parameter int BEATS_PER_BAR   = 8,
  parameter int ACCENT_EVERY    = 4,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int BEEP_CYCLES     = 5400000
) (
  input logic clk,
  input logic rst_n,
  metronome_beat_sequencer_if.slave bus
);
  localparam logic [31:0] LIMIT = 32'(64'(CLK_HZ) * 60);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam int AW = $clog2(ACCENT_EVERY + 1);
  logic [1:0] raw, ev;
  assign raw = {bus.btn_dn_n, bus.btn_up_n};
  // ev[b] pulses once when button b's accepted level falls from released to pressed
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic s1, s2, st, e;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
        st <= 1'b1;
        e <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        e <= 1'b0;
        if (s2 == st) cnt <= '0;
        else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          st <= s2;
          e <= ~s2;
        end else cnt <= cnt + 1'b1;
      end
    assign ev[g] = e;
  end
  logic [7:0] bpm, up_n, dn_n;
  logic [8:0] up_v;
  always_comb begin
    up_v = {1'b0, bpm} + 9'(BPM_STEP);
    up_n = (up_v > 9'(BPM_MAX)) ? 8'(BPM_MAX) : up_v[7:0];
    dn_n = (bpm < 8'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN) : bpm - 8'(BPM_STEP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bpm <= 8'(BPM_RESET);
    else bpm <= (ev == 2'b01) ? up_n : (ev == 2'b10) ? dn_n : bpm;
  logic [31:0] acc, acc_n;
  logic [32:0] sum;
  logic run_q, start, hit, fire, first, tick, acc_flag;
  logic [3:0] num;
  logic [AW-1:0] acnt, acnt_n;
  logic [BW-1:0] beep_cnt;
  always_comb begin
    start = bus.run & ~run_q;
    sum = {1'b0, acc} + {25'b0, bpm};
    hit = sum >= {1'b0, LIMIT};
    acc_n = start ? '0 : hit ? 32'(sum - {1'b0, LIMIT}) : sum[31:0];
    fire = start | (bus.run & hit);
    first = start | (num == 4'(BEATS_PER_BAR));
    acnt_n = (first || acnt == AW'(ACCENT_EVERY - 1)) ? '0 : acnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q <= 1'b0;
      tick <= 1'b0;
      acc <= '0;
      num <= 4'd1;
      acc_flag <= 1'b0;
      acnt <= '0;
      beep_cnt <= '0;
    end else begin
      run_q <= bus.run;
      tick <= fire;
      if (!bus.run) begin
        acc <= '0;
        num <= 4'd1;
        acc_flag <= 1'b0;
        acnt <= '0;
        beep_cnt <= '0;
      end else begin
        acc <= acc_n;
        beep_cnt <= fire ? BW'(BEEP_CYCLES) : (beep_cnt != '0) ? beep_cnt - 1'b1 : '0;
        if (fire) begin
          num <= first ? 4'd1 : num + 4'd1;
          acnt <= acnt_n;
          acc_flag <= acnt_n == '0;
        end
      end
    end
  assign bus.beat_tick = tick;
  assign bus.beat_num = num;
  assign bus.accent = acc_flag;
  assign bus.beep_en = beep_cnt != '0;
  assign bus.bpm = bpm;
endmodule

// File: tb/tb_metronome_beat_sequencer.sv
// tb_metronome_beat_sequencer: directed stimulus against a beat-count/tempo model, checked every cycle
module tb_metronome_beat_sequencer;
  localparam int DB = 5, BEEP = 20, BEEP2 = 150;
  localparam longint LIM = 6000;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  metronome_beat_sequencer_if m();
  metronome_beat_sequencer_if b();
  assign b.run = m.run;
  assign b.btn_up_n = m.btn_up_n;
  assign b.btn_dn_n = m.btn_dn_n;
  metronome_beat_sequencer #(.CLK_HZ(100), .DEBOUNCE_CYCLES(DB), .BEEP_CYCLES(BEEP)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
  metronome_beat_sequencer #(.CLK_HZ(100), .DEBOUNCE_CYCLES(DB), .BEEP_CYCLES(BEEP2)) u_long (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  int m_bpm = 60;
  bit bpm_chk = 1, mr_q = 0, e_tick = 0, e_acc = 0, e_run = 0;
  int e_num = 1;
  longint n = 0, k = 0, since = 0;
  // beat k fires on the running cycle where floor(n*bpm/LIMIT) steps up
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr_q = 0; n = 0; k = 0; since = 0;
      e_tick = 0; e_num = 1; e_acc = 0; e_run = 0; m_bpm = 60;
    end else begin
      e_tick = 0;
      if (m.run && !mr_q) begin
        n = 0; k = 0; e_tick = 1;
      end else if (m.run) begin
        n++;
        if ((n * m_bpm) / LIM != ((n - 1) * m_bpm) / LIM) begin
          k++; e_tick = 1;
        end
      end
      since = e_tick ? 0 : since + 1;
      e_run = m.run;
      e_num = m.run ? int'(k % 8) + 1 : 1;
      e_acc = m.run && ((k % 8) % 4 == 0);
      mr_q = m.run;
    end
  end
  always @(negedge clk) begin
    chk("beat_tick", m.beat_tick, e_tick);
    chk("beat_num", m.beat_num, e_num);
    chk("accent", m.accent, e_acc);
    chk("beep_en", m.beep_en, e_run && since < BEEP);
    chk("beep_en_long", b.beep_en, e_run && since < BEEP2);
    if (bpm_chk) chk("bpm", m.bpm, m_bpm);
  end
  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic press(input bit up, input bit dn, input int low);
    bpm_chk = 0;
    m.btn_up_n = ~up;
    m.btn_dn_n = ~dn;
    step(low);
    m.btn_up_n = 1;
    m.btn_dn_n = 1;
    step(12);
    if (low >= DB && up && !dn) m_bpm = (m_bpm + 4 > 240) ? 240 : m_bpm + 4;
    if (low >= DB && dn && !up) m_bpm = (m_bpm - 4 < 40) ? 40 : m_bpm - 4;
    bpm_chk = 1;
  endtask
  initial begin
    m.run = 0; m.btn_up_n = 1; m.btn_dn_n = 1;
    step(3);
    rst_n = 1;
    step(1);
    chk("rst_bpm", m.bpm, 60);
    chk("rst_num", m.beat_num, 1);
    chk("rst_tick", m.beat_tick, 0);
    chk("rst_beep", m.beep_en, 0);
    m.run = 1;
    step(1);
    chk("start_tick", m.beat_tick, 1);
    chk("start_accent", m.accent, 1);
    step(100);
    chk("beat2_tick", m.beat_tick, 1);
    chk("beat2_num", m.beat_num, 2);
    chk("beat2_accent", m.accent, 0);
    step(300);
    chk("beat5_num", m.beat_num, 5);
    chk("beat5_accent", m.accent, 1);
    step(400);
    chk("wrap_num", m.beat_num, 1);
    step(50);
    m.run = 0;
    step(1);
    chk("stop_beep", m.beep_en, 0);
    chk("stop_num", m.beat_num, 1);
    press(1, 0, 3);
    chk("glitch_bpm", m.bpm, 60);
    press(1, 0, 12);
    chk("up_bpm", m.bpm, 64);
    repeat (46) press(1, 0, 12);
    chk("max_bpm", m.bpm, 240);
    press(1, 1, 12);
    chk("both_bpm", m.bpm, 240);
    repeat (52) press(0, 1, 12);
    chk("min_bpm", m.bpm, 40);
    m.run = 1;
    step(400);
    chk("retrigger_beep", b.beep_en, 1);
    m.run = 0;
    step(1);
    chk("stop_beep_long", b.beep_en, 0);
    repeat (13) press(1, 0, 12);
    chk("bpm92", m.bpm, 92);
    m.run = 1;
    step(1);
    step(66);
    chk("bpm92_interval", m.beat_tick, 1);
    step(300);
    m.run = 0;
    step(1);
    repeat (2) press(1, 0, 12);
    m.run = 1;
    step(301);
    chk("beat6_num", m.beat_num, 6);
    step(10);
    m.btn_up_n = 0;
    step(3);
    #1 rst_n = 0;
    #1;
    chk("arst_num", m.beat_num, 1);
    chk("arst_beep", m.beep_en, 0);
    chk("arst_accent", m.accent, 0);
    chk("arst_bpm", m.bpm, 60);
    m.btn_up_n = 1;
    step(3);
    rst_n = 1;
    step(1);
    chk("restart_tick", m.beat_tick, 1);
    chk("restart_num", m.beat_num, 1);
    step(100);
    chk("restart_beat2", m.beat_num, 2);
    m.run = 0;
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
